lift_call_panel: RTL
====================

Name: lift_call_panel

Overview:
Request-side controller for the lift: collects hall-call and in-car floor button presses and queues them as pending bits. It presents one floor request at a time to the lift on the pass_f / butt_el request lines, then watches the lift's floor output to detect service. Once a call is served it clears the call and issues the next one. Sits between the floor/car button inputs and the lift controller.

Parameters:
NUM_FLOORS, 7, number of floors served (floor numbers 1..NUM_FLOORS); must be less than or equal to 7.
HOLD_CYCLES, 4, consecutive cycles elev_f_i must equal the target floor for the call to count as served (covers the door cycle).
GAP_CYCLES, 2, cycles the request lines are driven to 0 after service, so the lift returns to WAIT.
TIMEOUT_CYCLES, 64, dispatch timeout; used only with CALL_TIMEOUT_EN.

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous reset, active-high
hall_btn_i  in  NUM_FLOORS  hall-call buttons; bit i = floor i+1; level, may be held
car_btn_i  in  NUM_FLOORS  in-car floor buttons; same encoding
elev_f_i  in  3  current lift floor, from the lift's elev_f_o
busy_i  in  1  lift busy flag; informational only, mirrored to status
pass_f_o  out  3  hall request floor to the lift; 0 = no request
butt_el_o  out  3  car request floor to the lift; 0 = no request
hall_pend_o  out  NUM_FLOORS  hall-call lamps = pending hall bits
car_pend_o  out  NUM_FLOORS  car-call lamps = pending car bits
req_active_o  out  1  1 while a request is being driven (ISSUE/SERVE)
err_o  out  1  sticky timeout flag; 0 when CALL_TIMEOUT_EN is off

Behaviour:
- Reset: all pending bits, outputs, counters and the target register are 0; state is IDLE.
- Buttons are rising-edge detected with a 1-cycle registered history. A held button sets its pending bit once only.
- Pending bit set: one cycle after the edge. If a set and a clear hit the same bit in the same cycle, the set wins.
- Only one of pass_f_o / butt_el_o is nonzero in any cycle. Both are registered outputs.
- States:
  - IDLE: if any pending bit is set, go to SELECT; otherwise stay.
  - SELECT (1 cycle): choose the pending floor with minimum |floor - elev_f_i| across hall and car calls. Tie on distance: lower floor wins. Same floor pending as both hall and car: the car call wins, and both bits are cleared on service. Latch the target floor and its type; go to ISSUE.
  - ISSUE: drive the target onto butt_el_o (car call) or pass_f_o (hall call). Go to SERVE next cycle.
  - SERVE: keep driving the request. hold_cnt increments while elev_f_i equals the target and resets to 0 otherwise. When hold_cnt reaches HOLD_CYCLES-1 with elev_f_i still equal to the target: clear the served pending bit(s), drive both request lines to 0, go to GAP.
  - GAP: request lines stay 0 for GAP_CYCLES cycles, then go to IDLE.
- Target equal to the current floor is still dispatched (the lift runs its door cycle); service then takes HOLD_CYCLES cycles in SERVE.
- New presses arriving during SERVE/GAP only set pending bits; the current target is never preempted.
- Latency: press edge to request on the output, from IDLE with the lift idle, is 4 cycles (edge register, pending set, SELECT, ISSUE).
- Button bits at index NUM_FLOORS..6 do not exist. elev_f_i values of 0 or greater than NUM_FLOORS never match any target.
- Reset mid-operation: everything is cleared in the same cycle; pending calls are lost.

Optional Feature:
CALL_TIMEOUT_EN. When defined: a counter runs in ISSUE/SERVE. If TIMEOUT_CYCLES elapse without service, the request is dropped: its pending bit is cleared, err_o is set (sticky until rst), and the FSM goes to GAP. When undefined: no counter, err_o is tied to 0, and SERVE waits indefinitely.

Test Plan:
- Reset, then hall_btn_i=7'b0000100 with elev_f_i=1 → pass_f_o=3 four cycles later, butt_el_o=0, hall_pend_o[2]=1. Hold elev_f_i=3 for 4 cycles → pass_f_o=0, hall_pend_o=0, then IDLE after GAP.
- Pending car floor 2 and hall floor 6 with elev_f_i=4 → floor 2 and floor 6 tie at distance 2; lower floor wins, so butt_el_o=2 is issued first, then pass_f_o=6.
- Hall and car both pressed for floor 5 → butt_el_o=5 only; after service both hall_pend_o[4] and car_pend_o[4] are 0.
- Button held high for 50 cycles across a service → the call is served once and not re-queued. A release-and-repress during SERVE of that same floor re-sets the bit, and the floor is served again.
- rst asserted during SERVE with 3 calls pending → next cycle all outputs are 0, all lamps are 0, state is IDLE.
- CALL_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, target 7 with elev_f_i stuck at 1 → at cycle 64 pass_f_o=0, err_o=1, hall_pend_o[6]=0.

Source files
------------

// File: rtl/lift_call_panel_if.sv
// Button, floor and request signals between the call panel, the buttons and the lift.
interface lift_call_panel_if #(
  parameter int unsigned NUM_FLOORS = 7
);
  logic [NUM_FLOORS-1:0] hall_btn_i;
  logic [NUM_FLOORS-1:0] car_btn_i;
  logic [2:0]            elev_f_i;
  logic                  busy_i;
  logic [2:0]            pass_f_o;
  logic [2:0]            butt_el_o;
  logic [NUM_FLOORS-1:0] hall_pend_o;
  logic [NUM_FLOORS-1:0] car_pend_o;
  logic                  req_active_o;
  logic                  err_o;

  // Call panel side: takes buttons and lift floor, drives requests and lamps.
  modport master (
    input  hall_btn_i, car_btn_i, elev_f_i, busy_i,
    output pass_f_o, butt_el_o, hall_pend_o, car_pend_o, req_active_o, err_o
  );

  // Environment side: buttons and lift.
  modport slave (
    output hall_btn_i, car_btn_i, elev_f_i, busy_i,
    input  pass_f_o, butt_el_o, hall_pend_o, car_pend_o, req_active_o, err_o
  );
endinterface

// File: rtl/lift_call_panel.sv
// Lift call panel: queues hall/car button presses as pending bits and issues
// the nearest pending floor to the lift, one request at a time.
// Optional dispatch timeout enabled by defining CALL_TIMEOUT_EN.
module lift_call_panel #(
  parameter int unsigned NUM_FLOORS     = 7,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  lift_call_panel_if.master bus
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
`ifdef CALL_TIMEOUT_EN
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_ISSUE  = 3'd2,
    S_SERVE  = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_FLOORS-1:0] hall_hist_q, car_hist_q;
  logic [NUM_FLOORS-1:0] hall_edge_q, car_edge_q;
  logic [NUM_FLOORS-1:0] hall_pend_q, car_pend_q;
  logic [NUM_FLOORS-1:0] hall_clr, car_clr;
  logic [NUM_FLOORS-1:0] tgt_mask;
  logic [2:0]            tgt_q, tgt_d;
  logic                  tgt_car_q, tgt_car_d;
  logic [2:0]            pass_q, pass_d;
  logic [2:0]            butt_q, butt_d;
  logic                  req_q, req_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  at_target;

  logic                  sel_valid;
  logic                  sel_car;
  logic [2:0]            sel_floor;
  logic [2:0]            best_dist, cur_dist, cand;

`ifdef CALL_TIMEOUT_EN
  logic [TO_W-1:0]       to_q, to_d;
  logic                  err_q, err_d;
`endif

  // busy_i is status-only; it does not steer dispatch.
  logic unused_ok;
  assign unused_ok = ^{1'b0, bus.busy_i, 32'(TIMEOUT_CYCLES)};

  // Button history and registered rising-edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_hist_q <= '0;
      car_hist_q  <= '0;
      hall_edge_q <= '0;
      car_edge_q  <= '0;
    end else begin
      hall_hist_q <= bus.hall_btn_i;
      car_hist_q  <= bus.car_btn_i;
      hall_edge_q <= bus.hall_btn_i & ~hall_hist_q;
      car_edge_q  <= bus.car_btn_i & ~car_hist_q;
    end
  end

  // Pending call bits; a new press beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      hall_pend_q <= '0;
      car_pend_q  <= '0;
    end else begin
      hall_pend_q <= (hall_pend_q & ~hall_clr) | hall_edge_q;
      car_pend_q  <= (car_pend_q & ~car_clr) | car_edge_q;
    end
  end

  // Nearest pending floor; ascending scan with strict compare keeps the lower floor on ties.
  always_comb begin
    sel_valid = 1'b0;
    sel_car   = 1'b0;
    sel_floor = '0;
    best_dist = '0;
    cur_dist  = '0;
    cand      = '0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      cand     = 3'(f + 1);
      cur_dist = (cand >= bus.elev_f_i) ? (cand - bus.elev_f_i) : (bus.elev_f_i - cand);
      if ((hall_pend_q[f] || car_pend_q[f]) && (!sel_valid || (cur_dist < best_dist))) begin
        sel_valid = 1'b1;
        sel_car   = car_pend_q[f];
        sel_floor = cand;
        best_dist = cur_dist;
      end
    end
  end

  // One-hot of the latched target; floor 0 never matches.
  always_comb begin
    tgt_mask = '0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      tgt_mask[f] = (tgt_q == 3'(f + 1));
    end
  end

  assign at_target = (tgt_q != 3'd0) && (bus.elev_f_i == tgt_q);

  // Dispatch FSM: next state, registered request outputs and served-call clears.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    tgt_car_d = tgt_car_q;
    pass_d    = pass_q;
    butt_d    = butt_q;
    req_d     = req_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    hall_clr  = '0;
    car_clr   = '0;
`ifdef CALL_TIMEOUT_EN
    to_d      = to_q;
    err_d     = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        pass_d = '0;
        butt_d = '0;
        req_d  = 1'b0;
        if ((|hall_pend_q) || (|car_pend_q)) begin
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        hold_d = '0;
        if (sel_valid) begin
          tgt_d     = sel_floor;
          tgt_car_d = sel_car;
          pass_d    = sel_car ? 3'd0 : sel_floor;
          butt_d    = sel_car ? sel_floor : 3'd0;
          req_d     = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        hold_d  = '0;
        state_d = S_SERVE;
      end

      S_SERVE: begin
        if (at_target) begin
          if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            hall_clr = tgt_mask;
            car_clr  = tgt_car_q ? tgt_mask : '0;
            pass_d   = '0;
            butt_d   = '0;
            req_d    = 1'b0;
            hold_d   = '0;
            gap_d    = '0;
            state_d  = S_GAP;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end else begin
          hold_d = '0;
        end
      end

      S_GAP: begin
        pass_d = '0;
        butt_d = '0;
        req_d  = 1'b0;
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef CALL_TIMEOUT_EN
    // Drop a request the lift has not served within the timeout window.
    if (state_q == S_SELECT) begin
      to_d = '0;
    end else if (((state_q == S_ISSUE) || (state_q == S_SERVE)) && (state_d != S_GAP)) begin
      if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        hall_clr = tgt_mask;
        car_clr  = tgt_car_q ? tgt_mask : '0;
        pass_d   = '0;
        butt_d   = '0;
        req_d    = 1'b0;
        hold_d   = '0;
        gap_d    = '0;
        err_d    = 1'b1;
        state_d  = S_GAP;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
`endif
  end

  // FSM state, target and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      tgt_car_q <= 1'b0;
      pass_q    <= '0;
      butt_q    <= '0;
      req_q     <= 1'b0;
      hold_q    <= '0;
      gap_q     <= '0;
`ifdef CALL_TIMEOUT_EN
      to_q      <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      tgt_car_q <= tgt_car_d;
      pass_q    <= pass_d;
      butt_q    <= butt_d;
      req_q     <= req_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
`ifdef CALL_TIMEOUT_EN
      to_q      <= to_d;
      err_q     <= err_d;
`endif
    end
  end

  assign bus.pass_f_o     = pass_q;
  assign bus.butt_el_o    = butt_q;
  assign bus.hall_pend_o  = hall_pend_q;
  assign bus.car_pend_o   = car_pend_q;
  assign bus.req_active_o = req_q;
`ifdef CALL_TIMEOUT_EN
  assign bus.err_o        = err_q;
`else
  assign bus.err_o        = 1'b0;
`endif

endmodule
